// File: rtl/mesm6_bitunit.sv
// Iterative bit-manipulation unit: mask pack/unpack, double-width shift,
// population count and leading-zero count with end-around carry add.
module mesm6_bitunit #(
  parameter int WIDTH = 48,
  parameter int STEP  = 1,
  localparam int CW   = $clog2(WIDTH) + 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] rmr,
  output logic             busy,
  output logic             done
);

  localparam int NW   = $clog2(2*WIDTH + 1);
  localparam int KW   = $clog2(WIDTH + 1);
  localparam int ITER = WIDTH / STEP;

  if ((STEP < 1) || ((STEP & (STEP - 1)) != 0) || ((WIDTH % STEP) != 0)) begin : g_bad_step
    $error("mesm6_bitunit: STEP must be a power of two dividing WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_PACK, S_UNPACK, S_SHIFT, S_CARRY, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc_n, rmr_n, src, src_n, mask, mask_n;
  logic [NW-1:0]    cnt, cnt_n, shift_n, sh;
  logic [KW-1:0]    k, k_n, pop, z;
  logic [CW-1:0]    mag;
  logic             carry, carry_n, shift_left, shift_left_n;

  assign mag     = count[CW-1] ? (~count + 1'b1) : count;
  assign shift_n = (mag > CW'(2*WIDTH)) ? NW'(2*WIDTH) : NW'(mag);
  assign sh      = (cnt > NW'(STEP)) ? NW'(STEP) : cnt;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + KW'(a[i]);
  end

  // z ends up as WIDTH minus the index of the highest set bit, i.e. lzc+1
  always_comb begin
    z = '0;
    for (int i = 0; i < WIDTH; i++) if (a[i]) z = KW'(WIDTH - i);
  end

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    rmr_n        = rmr;
    src_n        = src;
    mask_n       = mask;
    cnt_n        = cnt;
    k_n          = k;
    carry_n      = carry;
    shift_left_n = shift_left;
    busy         = (state == S_PACK) || (state == S_UNPACK) ||
                   (state == S_SHIFT) || (state == S_CARRY);
    done         = (state == S_DONE);
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (start) begin
          src_n        = a;
          mask_n       = b;
          k_n          = '0;
          carry_n      = 1'b0;
          acc_n        = '0;
          rmr_n        = '0;
          shift_left_n = count[CW-1];
          cnt_n        = NW'(ITER);
          case (op)
            3'd0: state_n = S_PACK;
            3'd1: state_n = S_UNPACK;
            3'd2: begin
              state_n = S_SHIFT;
              acc_n   = a;
              cnt_n   = shift_n;
            end
            3'd3: begin
              state_n          = S_CARRY;
              {carry_n, acc_n} = {1'b0, b} + (WIDTH+1)'(pop);
            end
            3'd4: begin
              state_n          = S_CARRY;
              {carry_n, acc_n} = {1'b0, b} + (WIDTH+1)'(z);
              rmr_n            = a << z;
            end
            default: state_n = S_CARRY;
          endcase
        end
      end
      S_PACK: begin
        if (cnt == '0) state_n = S_DONE;
        else begin
          for (int j = 0; j < STEP; j++) begin
            if (mask_n[0]) begin
              acc_n[k_n] = src_n[0];
              k_n        = k_n + 1'b1;
            end
            mask_n = mask_n >> 1;
            src_n  = src_n >> 1;
          end
          cnt_n = cnt - 1'b1;
        end
      end
      // acc shifts left once per scanned position, so each inserted bit
      // lands back at the mask position it was scanned from
      S_UNPACK: begin
        if (cnt == '0) state_n = S_DONE;
        else begin
          for (int j = 0; j < STEP; j++) begin
            acc_n = {acc_n[WIDTH-2:0], mask_n[WIDTH-1] & src_n[WIDTH-1]};
            if (mask_n[WIDTH-1]) src_n = src_n << 1;
            mask_n = mask_n << 1;
          end
          cnt_n = cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) state_n = S_DONE;
        else begin
          if (shift_left) {rmr_n, acc_n} = {rmr, acc} << sh;
          else            {acc_n, rmr_n} = {acc, rmr} >> sh;
          cnt_n = cnt - sh;
        end
      end
      S_CARRY: begin
        acc_n   = acc + WIDTH'(carry);
        carry_n = 1'b0;
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      rmr        <= '0;
      src        <= '0;
      mask       <= '0;
      cnt        <= '0;
      k          <= '0;
      carry      <= 1'b0;
      shift_left <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      rmr        <= rmr_n;
      src        <= src_n;
      mask       <= mask_n;
      cnt        <= cnt_n;
      k          <= k_n;
      carry      <= carry_n;
      shift_left <= shift_left_n;
    end
  end

endmodule

// File: tb/tb_mesm6_bitunit.sv
// Directed bench for mesm6_bitunit: one STEP=1 and one STEP=4 instance
// sharing clock, reset and operands, each with its own start.
module tb_mesm6_bitunit;

  logic        clk = 1'b0;
  logic        reset, start1, start4;
  logic [2:0]  op;
  logic [47:0] a, b;
  logic [8:0]  count;
  logic [47:0] acc1, rmr1, acc4, rmr4;
  logic        busy1, done1, busy4, done4;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mesm6_bitunit #(.WIDTH(48), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .count(count), .acc(acc1), .rmr(rmr1), .busy(busy1), .done(done1)
  );

  mesm6_bitunit #(.WIDTH(48), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b),
    .count(count), .acc(acc4), .rmr(rmr4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // poke>0: re-assert start with op=COUNT while busy, poke cycles after acceptance
  task automatic run(input string tag, input bit use4, input logic [2:0] o,
                     input logic [47:0] av, input logic [47:0] bv, input logic [8:0] cv,
                     input logic [47:0] eacc, input logic [47:0] ermr,
                     input int elat, input int poke);
    int lat;
    bit seen;
    @(negedge clk);
    op = o; a = av; b = bv; count = cv;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    a = ~av; b = ~bv; count = ~cv; op = ~o;
    check({tag, " busy"}, use4 ? busy4 : busy1, 1'b1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      seen = use4 ? done4 : done1;
      start1 = 1'b0; start4 = 1'b0;
      if (!seen && poke == lat) begin
        op = 3'd3;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
      end
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " acc"}, use4 ? acc4 : acc1, eacc);
    check({tag, " rmr"}, use4 ? rmr4 : rmr1, ermr);
    @(posedge clk); #1;
    check({tag, " done pulse"}, use4 ? done4 : done1, 1'b0);
    check({tag, " acc hold"}, use4 ? acc4 : acc1, eacc);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = '0; a = '0; b = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset acc", acc1, 48'h0);
    check("reset rmr", rmr1, 48'h0);
    check("reset busy", busy1, 1'b0);
    check("reset done", done1, 1'b0);
    reset = 1'b0;

    run("pack s1",     0, 3'd0, 48'h0000000000A5, 48'h0000000000F0, 9'h000, 48'h00000000000A, 48'h0, 49, 0);
    run("pack s4",     1, 3'd0, 48'h0000000000A5, 48'h0000000000F0, 9'h000, 48'h00000000000A, 48'h0, 13, 0);
    run("pack split",  1, 3'd0, 48'h123456789ABC, 48'hFF00000000FF, 9'h000, 48'h0000000012BC, 48'h0, 13, 0);
    run("unpack s4",   1, 3'd1, 48'hC00000000000, 48'h000000000011, 9'h000, 48'h000000000011, 48'h0, 13, 0);
    run("unpack s1",   0, 3'd1, 48'hC00000000000, 48'h000000000011, 9'h000, 48'h000000000011, 48'h0, 49, 0);
    run("unpack mid",  1, 3'd1, 48'hABCD00000000, 48'h0000FFFF0000, 9'h000, 48'h0000ABCD0000, 48'h0, 13, 0);
    run("shr 4",       0, 3'd2, 48'h800000000001, 48'h0, 9'h004, 48'h080000000000, 48'h100000000000, 5, 0);
    run("shl 1",       0, 3'd2, 48'h800000000001, 48'h0, 9'h1FF, 48'h000000000002, 48'h000000000001, 2, 0);
    run("shl 100",     0, 3'd2, 48'h800000000001, 48'h0, 9'h19C, 48'h0, 48'h0, 97, 0);
    run("sh 0",        0, 3'd2, 48'h800000000001, 48'h0, 9'h000, 48'h800000000001, 48'h0, 1, 0);
    run("shr 4 s4",    1, 3'd2, 48'h800000000001, 48'h0, 9'h004, 48'h080000000000, 48'h100000000000, 2, 0);
    run("shr 50 s4",   1, 3'd2, 48'h800000000001, 48'h0, 9'h032, 48'h0, 48'h200000000000, 14, 0);
    run("count ones",  0, 3'd3, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 9'h000, 48'h000000000030, 48'h0, 1, 0);
    run("count small", 0, 3'd3, 48'h00000000000F, 48'h000000000005, 9'h000, 48'h000000000009, 48'h0, 1, 0);
    run("clz",         0, 3'd4, 48'h010000000003, 48'h0, 9'h000, 48'h000000000008, 48'h000000000300, 1, 0);
    run("clz zero",    0, 3'd4, 48'h0, 48'h000000000005, 9'h000, 48'h000000000005, 48'h0, 1, 0);
    run("clz wrap",    0, 3'd4, 48'h800000000000, 48'hFFFFFFFFFFFF, 9'h000, 48'h000000000001, 48'h0, 1, 0);
    run("reserved",    0, 3'd6, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 9'h000, 48'h0, 48'h0, 1, 0);
    run("busy ignore", 0, 3'd0, 48'h0000000000A5, 48'h0000000000F0, 9'h000, 48'h00000000000A, 48'h0, 49, 5);

    // reset during the 10th UNPACK cycle
    @(negedge clk);
    op = 3'd1; a = '1; b = '1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("mid unpack busy", busy4, 1'b1);
    check("mid unpack acc nonzero", acc4 != 48'h0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid reset busy", busy4, 1'b0);
    check("mid reset done", done4, 1'b0);
    check("mid reset acc", acc4, 48'h0);
    check("mid reset rmr", rmr4, 48'h0);

    // start and reset at the same edge
    @(negedge clk);
    op = 3'd3; a = '1; b = '0; reset = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start1 = 1'b0;
    check("start+reset busy", busy1, 1'b0);
    check("start+reset done", done1, 1'b0);
    check("start+reset acc", acc1, 48'h0);

    run("first after reset", 0, 3'd3, 48'h000000000101, 48'h000000000010, 9'h000, 48'h000000000012, 48'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mesm6_bitunit.md
MESM6_BITUNIT -- requirements
Module: mesm6_bitunit

Interface
REQ-001 SHALL have parameter WIDTH, default 48, operand/result width in bits.
REQ-002 SHALL have parameter STEP, default 1, bits processed per iteration cycle; a power of two dividing WIDTH; any other value is an elaboration error.
REQ-003 SHALL have derived localparam CW = $clog2(WIDTH)+3, shift-count width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only when busy=0.
REQ-007 op  input  3  0 PACK, 1 UNPACK, 2 SHIFT, 3 COUNT, 4 CLZ, 5-7 reserved.
REQ-008 a  input  WIDTH  operand / source bits.
REQ-009 b  input  WIDTH  mask (PACK/UNPACK) or addend (COUNT/CLZ).
REQ-010 count  input  CW  signed shift count: positive = right, negative = left.
REQ-011 acc  output  WIDTH  primary result.
REQ-012 rmr  output  WIDTH  secondary result (Y register).
REQ-013 busy  output  1  operation in progress.
REQ-014 done  output  1  one-cycle pulse; acc/rmr valid.

Function
REQ-015 States: IDLE, PACK, UNPACK, SHIFT, CARRY, DONE; busy=1 exactly in PACK, UNPACK, SHIFT, CARRY.
REQ-016 start accepted at edge N only when state is IDLE or DONE (back-to-back allowed); op, a, b, count latched at edge N; later input changes have no effect.
REQ-017 start while busy=1 is ignored.
REQ-018 done=1 only in DONE, for exactly one cycle; DONE returns to IDLE unless start is accepted.
REQ-019 acc/rmr hold their DONE values until the next accepted start.
REQ-020 Latency L (done=1 in the cycle after edge N+L): PACK/UNPACK L=WIDTH/STEP+1; SHIFT L=ceil(n/STEP)+1; COUNT/CLZ/reserved L=1.
REQ-021 PACK: mask positions of b scanned LSB first, STEP per cycle; the k-th set mask bit (k from 0) copies a[pos] to acc[k]; upper acc bits are 0; rmr=0.
REQ-022 UNPACK: mask positions scanned MSB first, STEP per cycle; the k-th set mask bit from the top receives a[WIDTH-1-k]; other acc bits are 0; rmr=0.
REQ-023 SHIFT: n = min(|count|, 2*WIDTH); load acc=a, rmr=0.
REQ-024 SHIFT, positive count: the 2*WIDTH concatenation {acc,rmr} is logically shifted right by n.
REQ-025 SHIFT, negative count: the concatenation {rmr,acc} is logically shifted left by n.
REQ-026 SHIFT: each cycle shifts min(STEP, remaining) bits; count=0 gives acc=a, rmr=0.
REQ-027 COUNT: at edge N, {carry,acc} = popcount(a)+b (WIDTH+1 bits); at edge N+1 (CARRY), acc = acc+carry, modulo 2^WIDTH (end-around carry); rmr=0.
REQ-028 CLZ: z = leading-zero count of a plus 1, or 0 when a=0.
REQ-029 CLZ: acc is the end-around sum z+b, as in COUNT; rmr = a<<z truncated to WIDTH.
REQ-030 Reserved op: acc=0, rmr=0.
REQ-031 Iteration counters are sized so that WIDTH/STEP and 2*WIDTH cannot wrap.

Reset
REQ-032 reset=1 at an edge forces state IDLE and acc=0, rmr=0, busy=0, done=0, regardless of state, including mid-operation.
REQ-033 reset and start asserted at the same edge: reset wins, start is discarded.
REQ-034 The first start is accepted at the first edge after reset deasserts.

Verification
REQ-035 WIDTH=48, STEP=1, PACK, a=0x0000000000A5, b=0x0000000000F0 -> acc=0x00000000000A, rmr=0, done after edge N+49.
REQ-036 STEP=4, UNPACK, a=0xC00000000000, b=0x000000000011 -> acc=0x000000000011, done after edge N+13.
REQ-037 SHIFT, a=0x800000000001: count=+4 -> acc=0x080000000000, rmr=0x100000000000, L=5; count=-1 -> acc=0x000000000002, rmr=0x000000000001, L=2; count=-100 -> acc=rmr=0, L=97.
REQ-038 COUNT, a=0xFFFFFFFFFFFF, b=0xFFFFFFFFFFFF -> acc=0x000000000030, L=1.
REQ-039 CLZ, a=0x010000000003, b=0 -> acc=0x000000000008, rmr=0x000000000300.
REQ-040 reset at the 10th UNPACK cycle -> next cycle busy=0, done=0, acc=rmr=0.
REQ-041 start during busy -> ignored, original result unchanged.
REQ-042 start+reset at the same edge -> remains IDLE.
